// File: rtl/gem_fiber_in_if.sv
// RX-side bundle for the GEM trigger fiber deframer: decoded GTX word stream in,
// reassembled GEM frame, lock status and error counter out.
interface gem_fiber_in_if #(
  parameter int CNT_W = 16
);
  logic             RX_VALID;
  logic [31:0]      RX_DATA;
  logic [3:0]       RX_ISK;
  logic             ERR_CNT_CLR;
  logic [55:0]      GEM_DATA;
  logic             GEM_OVERFLOW;
  logic             GEM_VALID;
  logic [1:0]       BX_SEQ;
  logic             LOCKED;
  logic             SEP_ERR;
  logic             IDLE_DET;
  logic [CNT_W-1:0] ERR_CNT;

  modport master (
    output RX_VALID, RX_DATA, RX_ISK, ERR_CNT_CLR,
    input  GEM_DATA, GEM_OVERFLOW, GEM_VALID, BX_SEQ, LOCKED, SEP_ERR, IDLE_DET, ERR_CNT
  );

  modport slave (
    input  RX_VALID, RX_DATA, RX_ISK, ERR_CNT_CLR,
    output GEM_DATA, GEM_OVERFLOW, GEM_VALID, BX_SEQ, LOCKED, SEP_ERR, IDLE_DET, ERR_CNT
  );
endinterface

// File: rtl/gem_fiber_in.sv
// GEM trigger fiber deframer: rebuilds 56-bit frames from A/B word pairs, locks on the
// BC/F7/FB/FD separator rotation, one cycle from B word to registered outputs.
module gem_fiber_in #(
  parameter int LOCK_FRAMES = 4,
  parameter int UNLOCK_ERRS = 3,
  parameter int CNT_W       = 16
) (
  input  logic          TRG_CLK80,
  input  logic          TRG_RST_N,
  gem_fiber_in_if.slave rx
);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_ERRS - 1);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t           state_q;
  logic             phase_q;
  logic [1:0]       exp_q;
  logic [GW-1:0]    good_cnt_q;
  logic [BW-1:0]    bad_cnt_q;
  logic             a_ok_q;
  logic [31:0]      a_dat_q;
  logic [55:0]      gem_data_q;
  logic             gem_ovf_q;
  logic             gem_vld_q;
  logic [1:0]       bx_q;
  logic             locked_q;
  logic             sep_err_q;
  logic             idle_det_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;

  logic [7:0] sep;
  logic       sep_known;
  logic [1:0] sep_idx;
  logic       is_fc;
  logic       a_ok;
  logic       b_ok;
  logic       idle;
  logic       frame_good;
  logic       err_inc;

  assign sep = rx.RX_DATA[7:0];

  always_comb begin
    sep_known = 1'b1;
    sep_idx   = 2'd0;
    case (sep)
      8'hBC:   sep_idx = 2'd0;
      8'hF7:   sep_idx = 2'd1;
      8'hFB:   sep_idx = 2'd2;
      8'hFD:   sep_idx = 2'd3;
      8'hFC:   sep_idx = 2'd0;
      default: sep_known = 1'b0;
    endcase
  end

  assign is_fc      = (sep == 8'hFC);
  assign a_ok       = rx.RX_VALID && (rx.RX_ISK == 4'b0000);
  assign b_ok       = rx.RX_VALID && (rx.RX_ISK == 4'b0001) && sep_known;
  assign idle       = rx.RX_VALID && (rx.RX_DATA == 32'h50BC50BC) && (rx.RX_ISK == 4'b0101);
  // Overflow frames carry no index of their own, so they always match the rotation.
  assign frame_good = a_ok_q && b_ok && (is_fc || (sep_idx == exp_q));
  assign err_inc    = (state_q == LOCKED) && rx.RX_VALID && !idle && phase_q && !frame_good;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (rx.ERR_CNT_CLR) begin
      err_cnt_d = '0;
    end else if (err_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
    if (!TRG_RST_N) begin
      state_q    <= HUNT;
      phase_q    <= 1'b0;
      exp_q      <= 2'd0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      a_ok_q     <= 1'b0;
      a_dat_q    <= '0;
      gem_data_q <= '0;
      gem_ovf_q  <= 1'b0;
      gem_vld_q  <= 1'b0;
      bx_q       <= 2'd0;
      locked_q   <= 1'b0;
      sep_err_q  <= 1'b0;
      idle_det_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      gem_vld_q  <= 1'b0;
      sep_err_q  <= 1'b0;
      idle_det_q <= 1'b0;
      a_ok_q     <= a_ok;
      a_dat_q    <= rx.RX_DATA;
      phase_q    <= ~phase_q;
      err_cnt_q  <= err_cnt_d;

      if (!rx.RX_VALID || idle) begin
        state_q    <= HUNT;
        locked_q   <= 1'b0;
        idle_det_q <= idle;
      end else begin
        case (state_q)
          HUNT: begin
            // Acquisition: this cycle is a B slot, so the next one is an A slot.
            if (a_ok_q && b_ok && !is_fc) begin
              state_q    <= CHECK;
              phase_q    <= 1'b0;
              exp_q      <= sep_idx + 2'd1;
              good_cnt_q <= GW'(1);
            end
          end
          CHECK: begin
            if (phase_q) begin
              exp_q <= exp_q + 2'd1;
              if (!frame_good) begin
                state_q <= HUNT;
              end else if (good_cnt_q == GOOD_LAST) begin
                state_q   <= LOCKED;
                locked_q  <= 1'b1;
                bad_cnt_q <= '0;
              end else begin
                good_cnt_q <= good_cnt_q + GW'(1);
              end
            end
          end
          LOCKED: begin
            if (phase_q) begin
              exp_q <= exp_q + 2'd1;
              if (frame_good) begin
                gem_vld_q  <= 1'b1;
                gem_data_q <= {a_dat_q, rx.RX_DATA[31:8]};
                gem_ovf_q  <= is_fc;
                bx_q       <= is_fc ? exp_q : sep_idx;
                bad_cnt_q  <= '0;
              end else begin
                sep_err_q <= 1'b1;
                if (bad_cnt_q == BAD_LAST) begin
                  state_q  <= HUNT;
                  locked_q <= 1'b0;
                end else begin
                  bad_cnt_q <= bad_cnt_q + BW'(1);
                end
              end
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx.GEM_DATA     = gem_data_q;
  assign rx.GEM_OVERFLOW = gem_ovf_q;
  assign rx.GEM_VALID    = gem_vld_q;
  assign rx.BX_SEQ       = bx_q;
  assign rx.LOCKED       = locked_q;
  assign rx.SEP_ERR      = sep_err_q;
  assign rx.IDLE_DET     = idle_det_q;
  assign rx.ERR_CNT      = err_cnt_q;
endmodule

// File: tb/tb_gem_fiber_in.sv
// Directed bench for gem_fiber_in: lock, overflow, separator errors, idle, counter saturation/clear, reset.
// A narrow error counter keeps the saturation case short.
module tb_gem_fiber_in;
  localparam int CNT_W = 8;
  localparam int ERR_MAX = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   nxt   = 0;
  int   exp_err = 0;
  logic [7:0]  seps [4] = '{8'hBC, 8'hF7, 8'hFB, 8'hFD};
  logic [55:0] d1 = 56'h123456789ABCDE;
  logic [55:0] d2 = 56'hFEDCBA98765432;

  gem_fiber_in_if #(.CNT_W(CNT_W)) bus ();

  gem_fiber_in #(
    .LOCK_FRAMES(4),
    .UNLOCK_ERRS(3),
    .CNT_W      (CNT_W)
  ) dut (
    .TRG_CLK80(clk),
    .TRG_RST_N(rst_n),
    .rx       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] k);
    bus.RX_DATA = d;
    bus.RX_ISK  = k;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [55:0] d, input logic [7:0] s, input logic clr);
    drive(d[55:24], 4'b0000);
    bus.ERR_CNT_CLR = clr;
    drive({d[23:0], s}, 4'b0001);
    bus.ERR_CNT_CLR = 1'b0;
  endtask

  task automatic good(input logic [55:0] d);
    send(d, seps[nxt], 1'b0);
    nxt = (nxt + 1) % 4;
  endtask

  // Sends the separator one step ahead of the expected one (a skipped index).
  task automatic bad(input logic [55:0] d, input logic clr);
    send(d, seps[(nxt + 1) % 4], clr);
    nxt = (nxt + 1) % 4;
    if (clr) exp_err = 0;
    else if (exp_err < ERR_MAX) exp_err++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.RX_VALID    = 1'b0;
    bus.RX_DATA     = '0;
    bus.RX_ISK      = '0;
    bus.ERR_CNT_CLR = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", bus.LOCKED, 0);
    chk("rst_gv", bus.GEM_VALID, 0);
    chk("rst_data", bus.GEM_DATA, 0);
    chk("rst_err", bus.ERR_CNT, 0);
    chk("rst_bx", bus.BX_SEQ, 0);
    chk("rst_seperr", bus.SEP_ERR, 0);
    chk("rst_idle", bus.IDLE_DET, 0);
    chk("rst_ovf", bus.GEM_OVERFLOW, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.RX_VALID = 1'b1;

    // Acquisition plus three more good frames -> locked, no strobes yet.
    for (int i = 0; i < 4; i++) begin
      good(d1);
      chk("t1_lock", bus.LOCKED, (i == 3));
      chk("t1_gv_check", bus.GEM_VALID, 0);
    end
    for (int i = 4; i < 8; i++) begin
      drive(d1[55:24], 4'b0000);
      chk("t1_gv_aslot", bus.GEM_VALID, 0);
      drive({d1[23:0], seps[nxt]}, 4'b0001);
      chk("t1_gv", bus.GEM_VALID, 1);
      chk("t1_data", bus.GEM_DATA, d1);
      chk("t1_bx", bus.BX_SEQ, nxt);
      chk("t1_ovf", bus.GEM_OVERFLOW, 0);
      nxt = (nxt + 1) % 4;
    end

    // Overflow frame takes the expected index; the rotation keeps going.
    send(d2, 8'hFC, 1'b0);
    chk("t2_gv", bus.GEM_VALID, 1);
    chk("t2_ovf", bus.GEM_OVERFLOW, 1);
    chk("t2_bx", bus.BX_SEQ, nxt);
    chk("t2_seperr", bus.SEP_ERR, 0);
    chk("t2_data", bus.GEM_DATA, d2);
    nxt = (nxt + 1) % 4;
    good(d1);
    chk("t2_next_gv", bus.GEM_VALID, 1);
    chk("t2_next_ovf", bus.GEM_OVERFLOW, 0);
    chk("t2_next_bx", bus.BX_SEQ, 1);
    chk("t2_next_seperr", bus.SEP_ERR, 0);

    // Single skipped separator, then three in a row.
    repeat (3) good(d1);
    bad(d2, 1'b0);
    chk("t3_seperr", bus.SEP_ERR, 1);
    chk("t3_err1", bus.ERR_CNT, exp_err);
    chk("t3_locked", bus.LOCKED, 1);
    chk("t3_gv", bus.GEM_VALID, 0);
    chk("t3_hold", bus.GEM_DATA, d1);
    good(d1);
    chk("t3_recover", bus.GEM_VALID, 1);
    for (int i = 0; i < 3; i++) begin
      bad(d2, 1'b0);
      chk("t3_run_locked", bus.LOCKED, (i < 2));
      chk("t3_run_gv", bus.GEM_VALID, 0);
    end
    chk("t3_err4", bus.ERR_CNT, exp_err);
    for (int i = 0; i < 4; i++) begin
      good(d1);
      chk("t3_relock", bus.LOCKED, (i == 3));
    end
    chk("t3_err_kept", bus.ERR_CNT, exp_err);

    // Idle word drops lock at once.
    good(d2);
    chk("t4_gv", bus.GEM_VALID, 1);
    drive(32'h50BC50BC, 4'b0101);
    chk("t4_idle", bus.IDLE_DET, 1);
    chk("t4_locked", bus.LOCKED, 0);
    for (int i = 0; i < 4; i++) begin
      good(d1);
      chk("t4_idle_off", bus.IDLE_DET, 0);
      chk("t4_relock", bus.LOCKED, (i == 3));
    end

    // Error counter saturation and clear-over-increment.
    for (int i = 0; i < 130; i++) begin
      bad(d2, 1'b0);
      bad(d2, 1'b0);
      good(d1);
    end
    chk("t5_sat", bus.ERR_CNT, exp_err);
    chk("t5_locked", bus.LOCKED, 1);
    bad(d2, 1'b0);
    chk("t5_sat_hold", bus.ERR_CNT, ERR_MAX);
    chk("t5_seperr", bus.SEP_ERR, 1);
    bad(d2, 1'b1);
    chk("t5_clr", bus.ERR_CNT, exp_err);
    chk("t5_clr_seperr", bus.SEP_ERR, 1);
    chk("t5_clr_locked", bus.LOCKED, 1);
    good(d1);
    chk("t5_after_gv", bus.GEM_VALID, 1);

    // Asynchronous reset in the middle of a frame.
    drive(d1[55:24], 4'b0000);
    chk("t6_pre_locked", bus.LOCKED, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_locked", bus.LOCKED, 0);
    chk("t6_rst_data", bus.GEM_DATA, 0);
    chk("t6_rst_err", bus.ERR_CNT, 0);
    chk("t6_rst_bx", bus.BX_SEQ, 0);
    chk("t6_rst_gv", bus.GEM_VALID, 0);
    exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) good(d1);
    chk("t6_relock", bus.LOCKED, 1);
    good(d2);
    chk("t6_gv", bus.GEM_VALID, 1);
    chk("t6_data", bus.GEM_DATA, d2);
    bus.RX_VALID = 1'b0;
    drive(d1[55:24], 4'b0000);
    chk("t6_rxv_locked", bus.LOCKED, 0);
    chk("t6_rxv_gv", bus.GEM_VALID, 0);
    chk("t6_rxv_hold", bus.GEM_DATA, d2);
    bus.RX_VALID = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
